// File: rtl/sr_flag_arbiter.sv
// Round-robin arbitrated bank of SR flags with optional per-requester burst lock.
// One flag op per clock, Q updates one edge after the grant cycle; ungranted requesters stall holding req.
module sr_flag_arbiter #(
    parameter int NREQ  = 4,
    parameter int NFLAG = 8,
    parameter int IDXW  = 3,
    parameter int ECW   = 8
) (
    input  logic                 clk,
    input  logic                 RST,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      lock,
    input  logic [2*NREQ-1:0]    op,
    input  logic [IDXW*NREQ-1:0] idx,
    output logic [NREQ-1:0]      gnt,
    output logic [NFLAG-1:0]     Q,
    output logic [NFLAG-1:0]     Qbar,
    output logic                 busy,
    output logic                 err,
    output logic [ECW-1:0]       err_cnt
);

    localparam int            PW      = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [IDXW:0] NFLAG_W = (IDXW+1)'(NFLAG);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    typedef struct packed {
        logic            lock;
        logic            s;
        logic            r;
        logic [IDXW-1:0] idx;
    } sel_t;

    state_t          state_q;
    state_t          state_d;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   owner;
    logic [PW-1:0]   pick;
    logic            pick_vld;
    logic [PW-1:0]   gnt_idx;
    logic            xfer;
    logic            req_owner;
    sel_t            sel;
    logic            legal;
    logic [NFLAG-1:0] q_nxt;

    // Two passes give the rotating search: first rr_ptr..NREQ-1, then 0..rr_ptr-1.
    always_comb begin
        pick_vld = 1'b0;
        pick     = '0;
        for (int r = 0; r < NREQ; r++) begin
            if (!pick_vld && req[r] && (PW'(r) >= rr_ptr)) begin
                pick_vld = 1'b1;
                pick     = PW'(r);
            end
        end
        for (int r = 0; r < NREQ; r++) begin
            if (!pick_vld && req[r]) begin
                pick_vld = 1'b1;
                pick     = PW'(r);
            end
        end
    end

    always_comb begin
        req_owner = 1'b0;
        for (int r = 0; r < NREQ; r++) begin
            if (owner == PW'(r)) begin
                req_owner = req[r];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; an illegal op never enters or keeps OWN.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (xfer && legal && sel.lock) begin
                    state_d = OWN;
                end
            end
            OWN: begin
                if (!xfer || !legal || !sel.lock) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: grant depends only on req, state, rr_ptr and owner.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        xfer    = 1'b0;
        busy    = (state_q == OWN);
        if (RST) begin
            if (state_q == IDLE) begin
                if (pick_vld) begin
                    gnt_idx = pick;
                    xfer    = 1'b1;
                end
            end else if (req_owner) begin
                gnt_idx = owner;
                xfer    = 1'b1;
            end
            for (int r = 0; r < NREQ; r++) begin
                gnt[r] = xfer && (gnt_idx == PW'(r));
            end
        end
    end

    always_comb begin
        sel = '0;
        for (int r = 0; r < NREQ; r++) begin
            if (gnt_idx == PW'(r)) begin
                sel.lock       = lock[r];
                {sel.s, sel.r} = op[2*r +: 2];
                sel.idx        = idx[IDXW*r +: IDXW];
            end
        end
    end

    assign legal = ({1'b0, sel.idx} < NFLAG_W) && !(sel.s && sel.r);

    always_comb begin
        q_nxt = Q;
        for (int f = 0; f < NFLAG; f++) begin
            if (sel.idx == IDXW'(f)) begin
                if (sel.s && !sel.r) begin
                    q_nxt[f] = 1'b1;
                end else if (!sel.s && sel.r) begin
                    q_nxt[f] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            rr_ptr  <= '0;
            owner   <= '0;
            Q       <= '0;
            err     <= 1'b0;
            err_cnt <= '0;
        end else begin
            if (xfer) begin
                rr_ptr <= (gnt_idx == PW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
            end
            if ((state_q == IDLE) && (state_d == OWN)) begin
                owner <= gnt_idx;
            end
            if (xfer && legal) begin
                Q <= q_nxt;
            end
            err <= xfer && !legal;
            if (xfer && !legal && (err_cnt != '1)) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end

    assign Qbar = ~Q;

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Directed bench for sr_flag_arbiter: main instance (IDXW=4 so out-of-range indices exist)
// plus a narrow-counter instance (ECW=2) for saturation.
module tb_sr_flag_arbiter;

    logic        clk;
    logic        RST;
    logic [3:0]  req, lock;
    logic [7:0]  op;
    logic [15:0] idx;
    logic [3:0]  gnt;
    logic [7:0]  Q, Qbar;
    logic        busy, err;
    logic [7:0]  err_cnt;

    logic [3:0]  s_req, s_lock;
    logic [7:0]  s_op;
    logic [11:0] s_idx;
    logic [3:0]  s_gnt;
    logic [7:0]  s_Q, s_Qbar;
    logic        s_busy, s_err;
    logic [1:0]  s_err_cnt;

    int n_chk = 0;
    int n_err = 0;

    sr_flag_arbiter #(.NREQ(4), .NFLAG(8), .IDXW(4), .ECW(8)) u_dut (
        .clk(clk), .RST(RST), .req(req), .lock(lock), .op(op), .idx(idx),
        .gnt(gnt), .Q(Q), .Qbar(Qbar), .busy(busy), .err(err), .err_cnt(err_cnt)
    );

    sr_flag_arbiter #(.NREQ(4), .NFLAG(8), .IDXW(3), .ECW(2)) u_sat (
        .clk(clk), .RST(RST), .req(s_req), .lock(s_lock), .op(s_op), .idx(s_idx),
        .gnt(s_gnt), .Q(s_Q), .Qbar(s_Qbar), .busy(s_busy), .err(s_err), .err_cnt(s_err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    int sat_exp [5] = '{1, 2, 3, 3, 3};

    initial begin
        RST = 1'b0;
        req = 4'hF; lock = '0; op = '0; idx = '0;
        s_req = '0; s_lock = '0; s_op = '0; s_idx = '0;
        #12;
        chk("rst_q",      32'(Q),       32'h00);
        chk("rst_qbar",   32'(Qbar),    32'hFF);
        chk("rst_gnt",    32'(gnt),     32'h0);
        chk("rst_busy",   32'(busy),    32'h0);
        chk("rst_errcnt", 32'(err_cnt), 32'h0);
        req = '0;
        RST = 1'b1;
        tick();

        // Saturating counter on the ECW=2 instance.
        s_req = 4'h1; s_op = 8'h03; s_idx = '0;
        #1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("sat_cnt", 32'(s_err_cnt), 32'(sat_exp[i]));
        end
        chk("sat_q", 32'(s_Q), 32'h00);
        s_req = '0;

        // Round robin, all setting bit k+1.
        req = 4'hF; lock = '0; op = 8'hAA; idx = 16'h4321;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("rr_gnt", 32'(gnt), 32'(1 << k));
            tick();
        end
        chk("rr_q",    32'(Q),   32'h1E);
        chk("rr_wrap", 32'(gnt), 32'h1);
        req = 4'h1; op = 8'h01; idx = 16'h0001;
        #1;
        chk("clr_gnt", 32'(gnt), 32'h1);
        tick();
        chk("clr_q",    32'(Q),    32'h1C);
        chk("clr_qbar", 32'(Qbar), 32'hE3);
        chk("clr_err",  32'(err),  32'h0);

        // Illegal S=R=1 with lock set: consumed, counted, lock ignored.
        req = 4'h4; lock = 4'h4; op = 8'h30; idx = 16'h0400;
        #1;
        chk("ill1_gnt", 32'(gnt), 32'h4);
        tick();
        chk("ill1_err",  32'(err),     32'h1);
        chk("ill1_cnt",  32'(err_cnt), 32'h1);
        chk("ill1_q",    32'(Q),       32'h1C);
        chk("ill1_busy", 32'(busy),    32'h0);
        // Out-of-range index.
        req = 4'h2; lock = '0; op = 8'h08; idx = 16'h0090;
        #1;
        chk("ill2_gnt", 32'(gnt), 32'h2);
        tick();
        chk("ill2_cnt", 32'(err_cnt), 32'h2);
        chk("ill2_q",   32'(Q),       32'h1C);
        req = 4'h1; op = 8'h01; idx = 16'h0002;
        #1;
        chk("leg_gnt", 32'(gnt), 32'h1);
        tick();
        chk("leg_err", 32'(err),     32'h0);
        chk("leg_cnt", 32'(err_cnt), 32'h2);
        chk("leg_q",   32'(Q),       32'h18);

        // Burst by requester 1 while 0 and 3 wait.
        req = 4'hB; lock = 4'h2; op = 8'h08; idx = 16'h0000;
        #1;
        chk("b1_gnt",  32'(gnt),  32'h2);
        chk("b1_busy", 32'(busy), 32'h0);
        tick();
        chk("b1_q",    32'(Q),    32'h19);
        chk("b2_busy", 32'(busy), 32'h1);
        idx = 16'h0020;
        #1;
        chk("b2_gnt", 32'(gnt), 32'h2);
        tick();
        chk("b2_q",    32'(Q),    32'h1D);
        chk("b3_busy", 32'(busy), 32'h1);
        idx = 16'h0040; lock = '0;
        #1;
        chk("b3_gnt", 32'(gnt), 32'h2);
        tick();
        chk("b3_busy_end", 32'(busy), 32'h0);
        chk("b3_q",        32'(Q),    32'h1D);
        req = 4'h9;
        #1;
        chk("post_gnt3", 32'(gnt), 32'h8);
        tick();
        req = 4'h1;
        #1;
        chk("post_gnt0", 32'(gnt), 32'h1);
        tick();
        req = '0;

        // Owner 2 abandons the burst with requester 0 pending.
        req = 4'h5; lock = 4'h4; op = 8'h20; idx = 16'h0500;
        #1;
        chk("ab_gnt", 32'(gnt), 32'h4);
        tick();
        chk("ab_busy", 32'(busy), 32'h1);
        chk("ab_q",    32'(Q),    32'h3D);
        req = 4'h1; lock = '0;
        #1;
        chk("ab_stall", 32'(gnt), 32'h0);
        tick();
        chk("ab_idle", 32'(busy), 32'h0);
        chk("ab_q2",   32'(Q),    32'h3D);
        chk("ab_next", 32'(gnt),  32'h1);
        tick();
        req = '0;

        // Asynchronous reset in the middle of a burst.
        req = 4'h2; lock = 4'h2; op = 8'h08; idx = 16'h0070;
        #1;
        chk("mr_gnt", 32'(gnt), 32'h2);
        tick();
        chk("mr_busy", 32'(busy), 32'h1);
        chk("mr_q",    32'(Q),    32'hBD);
        #2;
        RST = 1'b0;
        #1;
        chk("mr_rst_q",    32'(Q),       32'h00);
        chk("mr_rst_qbar", 32'(Qbar),    32'hFF);
        chk("mr_rst_busy", 32'(busy),    32'h0);
        chk("mr_rst_gnt",  32'(gnt),     32'h0);
        chk("mr_rst_cnt",  32'(err_cnt), 32'h0);
        req = 4'h9; lock = '0; op = '0; idx = '0;
        #2;
        RST = 1'b1;
        #1;
        chk("mr_first", 32'(gnt), 32'h1);
        tick();
        chk("mr_second", 32'(gnt), 32'h8);
        req = '0;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
